// File: rtl/approx_adder_err_sweeper.sv
// Exhaustive error characteriser for one external W-bit approximate adder.
// Sweeps every operand pair, aligns the exact sum with the DUT latency and accumulates error metrics.
module approx_adder_err_sweeper #(
  parameter int W       = 8,
  parameter int DUT_LAT = 0,
  parameter int ACC_W   = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W:0]       approx_sum,
  output logic [2*W:0]     err_cnt,
  output logic [3*W+1:0]   err_sum,
  output logic [ACC_W-1:0] sse,
  output logic [W:0]       max_abs_err
);

  localparam int IW    = 2 * W;
  localparam int ERR_W = W + 2;
  localparam int SQ_W  = 2 * ERR_W;
  localparam int SUM_W = 3 * W + 2;
  localparam int CNT_W = 2 * W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, idx_nxt;
  logic [W-1:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DUT_LAT:0]   vld_q, vld_d;
  logic [W:0]         exact_q [DUT_LAT+1];
  logic [W:0]         exact_d [DUT_LAT+1];
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]   err_sum_q, err_sum_d;
  logic [ACC_W-1:0]   sse_q, sse_d;
  logic [W:0]         max_q, max_d;

  logic               head_vld, pending;
  logic signed [ERR_W-1:0] err_e, abs_e;
  logic signed [SQ_W-1:0]  err_sq;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    sse_d     = sse_q;
    max_d     = max_q;
    idx_nxt   = idx_q + IW'(1);

    // Stage 0 travels with the operand register; stages 1..DUT_LAT model the DUT latency.
    vld_d      = '0;
    exact_d[0] = exact_q[0];
    for (int i = 1; i <= DUT_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      exact_d[i] = exact_q[i-1];
    end

    head_vld = vld_q[DUT_LAT];
    pending  = 1'b0;
    for (int i = 0; i < DUT_LAT; i++) begin
      pending = pending | vld_q[i];
    end

    err_e  = signed'(ERR_W'(approx_sum)) - signed'(ERR_W'(exact_q[DUT_LAT]));
    abs_e  = err_e[ERR_W-1] ? -err_e : err_e;
    err_sq = err_e * err_e;

    if (head_vld) begin
      err_cnt_d = err_cnt_q + CNT_W'(err_e != '0);
      err_sum_d = err_sum_q + SUM_W'(err_e);
      sse_d     = sse_q + ACC_W'(err_sq);
      if (abs_e[W:0] > max_q) begin
        max_d = abs_e[W:0];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d    = S_RUN;
          idx_d      = '0;
          op_a_d     = '0;
          op_b_d     = '0;
          vld_d[0]   = 1'b1;
          exact_d[0] = '0;
          err_cnt_d  = '0;
          err_sum_d  = '0;
          sse_d      = '0;
          max_d      = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          vld_d   = '0;
        end else begin
          idx_d      = idx_nxt;
          op_a_d     = idx_nxt[IW-1:W];
          op_b_d     = idx_nxt[W-1:0];
          vld_d[0]   = 1'b1;
          exact_d[0] = {1'b0, idx_nxt[IW-1:W]} + {1'b0, idx_nxt[W-1:0]};
          if (&idx_nxt) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          vld_d   = '0;
        end else if (head_vld && !pending) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      vld_q     <= '0;
      err_cnt_q <= '0;
      err_sum_q <= '0;
      sse_q     <= '0;
      max_q     <= '0;
      for (int i = 0; i <= DUT_LAT; i++) begin
        exact_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      vld_q     <= vld_d;
      err_cnt_q <= err_cnt_d;
      err_sum_q <= err_sum_d;
      sse_q     <= sse_d;
      max_q     <= max_d;
      for (int i = 0; i <= DUT_LAT; i++) begin
        exact_q[i] <= exact_d[i];
      end
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign err_cnt     = err_cnt_q;
  assign err_sum     = err_sum_q;
  assign sse         = sse_q;
  assign max_abs_err = max_q;

endmodule

// File: tb/tb_approx_adder_err_sweeper.sv
// Directed bench: two 4-bit sweepers (latency 0 and 3) driving bench-side adder models.
module tb_approx_adder_err_sweeper;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  always #5 clk = ~clk;

  logic         busy0, done0, busy1, done1;
  logic [3:0]   op_a0, op_b0, op_a1, op_b1;
  logic [4:0]   approx0, approx1;
  logic [8:0]   err_cnt0, err_cnt1;
  logic [13:0]  err_sum0, err_sum1;
  logic [39:0]  sse0, sse1;
  logic [4:0]   max0, max1;

  int mode0, mode1;   // 0 exact, 1 approx_fa_3_127 ripple, 2 exact+1
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b, input int mode);
    logic [4:0] s;
    logic       c;
    s = '0;
    c = 1'b0;
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        s[i] = a[i] | b[i] | c;
        c    = a[i] & b[i];
      end
      s[3] = a[3] ^ b[3] ^ c;
      s[4] = (a[3] & b[3]) | (c & (a[3] ^ b[3]));
    end else if (mode == 2) begin
      s = {1'b0, a} + {1'b0, b} + 5'd1;
    end else begin
      s = {1'b0, a} + {1'b0, b};
    end
    return s;
  endfunction

  // Latency-0 DUT is combinational; latency-3 DUT registers its operands three times.
  assign approx0 = adder_model(op_a0, op_b0, mode0);
  logic [3:0] a_p1, a_p2, a_p3, b_p1, b_p2, b_p3;
  always @(posedge clk) begin
    a_p1 <= op_a1; a_p2 <= a_p1; a_p3 <= a_p2;
    b_p1 <= op_b1; b_p2 <= b_p1; b_p3 <= b_p2;
  end
  assign approx1 = adder_model(a_p3, b_p3, mode1);

  approx_adder_err_sweeper #(.W(W), .DUT_LAT(0), .ACC_W(40)) u_sw0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy0), .done(done0), .op_a(op_a0), .op_b(op_b0),
    .approx_sum(approx0), .err_cnt(err_cnt0), .err_sum(err_sum0),
    .sse(sse0), .max_abs_err(max0)
  );

  approx_adder_err_sweeper #(.W(W), .DUT_LAT(3), .ACC_W(40)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy1), .done(done1), .op_a(op_a1), .op_b(op_b1),
    .approx_sum(approx1), .err_cnt(err_cnt1), .err_sum(err_sum1),
    .sse(sse1), .max_abs_err(max1)
  );

  // Reference metrics over all 256 pairs, computed straight from the adder model.
  task automatic golden(input int mode, output int g_cnt, output int g_sum, output int g_sse, output int g_max);
    int e;
    g_cnt = 0; g_sum = 0; g_sse = 0; g_max = 0;
    for (int idx = 0; idx < 256; idx++) begin
      logic [3:0] a, b;
      a = 4'(idx >> 4);
      b = 4'(idx);
      e = int'(adder_model(a, b, mode)) - (int'(a) + int'(b));
      if (e != 0) g_cnt++;
      g_sum += e;
      g_sse += e * e;
      if ((e < 0 ? -e : e) > g_max) g_max = (e < 0 ? -e : e);
    end
  endtask

  // Pulse start and count edges until each instance reports done.
  task automatic do_sweep(output int t0, output int t1, output int bz);
    t0 = 0; t1 = 0; bz = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (busy0) bz++;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (done0 && t0 == 0) t0 = n;
      if (done1 && t1 == 0) t1 = n;
      if (busy0) bz++;
      if (t0 != 0 && t1 != 0) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode0 = 0; mode1 = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, done0, op_a0, op_b0, err_cnt0, err_sum0, sse0, max0} !== '0) begin
      n_bad++; $display("FAIL reset_inst0: got busy=%0b done=%0b cnt=%0d sum=%0d sse=%0d max=%0d, want all 0",
                        busy0, done0, err_cnt0, err_sum0, sse0, max0);
    end
    n_cmp++;
    if ({busy1, done1, op_a1, op_b1, err_cnt1, err_sum1, sse1, max1} !== '0) begin
      n_bad++; $display("FAIL reset_inst1: got busy=%0b done=%0b cnt=%0d sum=%0d sse=%0d max=%0d, want all 0",
                        busy1, done1, err_cnt1, err_sum1, sse1, max1);
    end
    @(negedge clk); rst_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_exact_and_plus1;
    int t0, t1, bz;
    mode0 = 0; mode1 = 2;
    do_sweep(t0, t1, bz);
    n_cmp++; if (t0 !== 256) begin n_bad++; $display("FAIL done_edge_lat0: got %0d want 256", t0); end
    n_cmp++; if (t1 !== 259) begin n_bad++; $display("FAIL done_edge_lat3: got %0d want 259", t1); end
    n_cmp++; if (bz !== 256) begin n_bad++; $display("FAIL busy_cycles: got %0d want 256", bz); end
    n_cmp++;
    if ({err_cnt0, err_sum0, sse0, max0} !== '0) begin
      n_bad++; $display("FAIL exact_metrics: got cnt=%0d sum=%0d sse=%0d max=%0d want 0/0/0/0",
                        err_cnt0, err_sum0, sse0, max0);
    end
    n_cmp++; if (err_cnt1 !== 9'd256) begin n_bad++; $display("FAIL plus1_cnt: got %0d want 256", err_cnt1); end
    n_cmp++; if (err_sum1 !== 14'd256) begin n_bad++; $display("FAIL plus1_sum: got %0d want 256", err_sum1); end
    n_cmp++; if (sse1 !== 40'd256) begin n_bad++; $display("FAIL plus1_sse: got %0d want 256", sse1); end
    n_cmp++; if (max1 !== 5'd1) begin n_bad++; $display("FAIL plus1_max: got %0d want 1", max1); end
    $display("exact/plus1 sweep: done edges %0d/%0d busy %0d", t0, t1, bz);
  endtask

  task automatic test_approx;
    int t0, t1, g_cnt, g_sum, g_sse, g_max;
    logic [8:0]  c17;
    logic [13:0] s17;
    logic [39:0] q17;
    mode0 = 1; mode1 = 1;
    t0 = 0; t1 = 0; c17 = '0; s17 = '0; q17 = '0;
    golden(1, g_cnt, g_sum, g_sse, g_max);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == 17) begin c17 = err_cnt0; s17 = err_sum0; q17 = sse0; end
      if (n == 18) begin
        // Pair a=1,b=1 is compared at this edge: approx 3 vs exact 2.
        n_cmp++; if (err_sum0 - s17 !== 14'd1) begin n_bad++; $display("FAIL trace_11_sum: delta %0d want 1", err_sum0 - s17); end
        n_cmp++; if (sse0 - q17 !== 40'd1) begin n_bad++; $display("FAIL trace_11_sse: delta %0d want 1", sse0 - q17); end
        n_cmp++; if (err_cnt0 - c17 !== 9'd1) begin n_bad++; $display("FAIL trace_11_cnt: delta %0d want 1", err_cnt0 - c17); end
      end
      if (done0 && t0 == 0) t0 = n;
      if (done1 && t1 == 0) t1 = n;
      if (t0 != 0 && t1 != 0) break;
    end
    n_cmp++; if (t0 !== 256) begin n_bad++; $display("FAIL approx_done_lat0: got %0d want 256", t0); end
    n_cmp++; if (t1 !== 259) begin n_bad++; $display("FAIL approx_done_lat3: got %0d want 259", t1); end
    n_cmp++;
    if ({err_cnt0, err_sum0, sse0, max0} !== {9'(g_cnt), 14'(g_sum), 40'(g_sse), 5'(g_max)}) begin
      n_bad++; $display("FAIL approx_metrics_lat0: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                        err_cnt0, $signed(err_sum0), sse0, max0, g_cnt, g_sum, g_sse, g_max);
    end
    n_cmp++;
    if ({err_cnt1, err_sum1, sse1, max1} !== {9'(g_cnt), 14'(g_sum), 40'(g_sse), 5'(g_max)}) begin
      n_bad++; $display("FAIL approx_metrics_lat3: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                        err_cnt1, $signed(err_sum1), sse1, max1, g_cnt, g_sum, g_sse, g_max);
    end
    $display("approx sweep: cnt=%0d sum=%0d sse=%0d max=%0d", err_cnt0, $signed(err_sum0), sse0, max0);
  endtask

  task automatic test_abort;
    int t0, t1, bz, g_cnt, g_sum, g_sse, g_max;
    logic saw_done;
    golden(1, g_cnt, g_sum, g_sse, g_max);
    // start together with abort while in DONE: nothing happens
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy0 !== 1'b0 || done0 !== 1'b1) begin
      n_bad++; $display("FAIL start_abort_same: busy=%0b done=%0b want busy=0 done=1", busy0, done0);
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    n_cmp++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL abort_to_idle: busy0=%0b done0=%0b busy1=%0b want 0/0/0", busy0, done0, busy1);
    end
    saw_done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy0) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: activity seen after abort, want none"); end
    do_sweep(t0, t1, bz);
    n_cmp++; if (t0 !== 256) begin n_bad++; $display("FAIL rerun_done_lat0: got %0d want 256", t0); end
    n_cmp++;
    if ({err_cnt0, err_sum0, sse0, max0} !== {9'(g_cnt), 14'(g_sum), 40'(g_sse), 5'(g_max)}) begin
      n_bad++; $display("FAIL rerun_metrics: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                        err_cnt0, $signed(err_sum0), sse0, max0, g_cnt, g_sum, g_sse, g_max);
    end
    $display("abort: idle after abort, rerun done at %0d", t0);
  endtask

  task automatic test_back_to_back;
    int t1;
    mode1 = 2;
    for (int pass = 0; pass < 2; pass++) begin
      t1 = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (pass == 1) begin
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || err_cnt1 !== 9'd0 || sse1 !== 40'd0) begin
          n_bad++; $display("FAIL restart_from_done: done=%0b busy=%0b cnt=%0d sse=%0d want 0/1/0/0",
                            done1, busy1, err_cnt1, sse1);
        end
      end
      for (int n = 1; n <= 400; n++) begin
        @(posedge clk); #1;
        if (n == 99) start = 1'b1;
        if (n == 100) start = 1'b0;
        if (done1 && t1 == 0) begin t1 = n; break; end
      end
      n_cmp++; if (t1 !== 259) begin n_bad++; $display("FAIL b2b_done_edge_pass%0d: got %0d want 259", pass, t1); end
      n_cmp++; if (err_cnt1 !== 9'd256) begin n_bad++; $display("FAIL b2b_cnt_pass%0d: got %0d want 256", pass, err_cnt1); end
      $display("back_to_back pass %0d: done edge %0d cnt %0d", pass, t1, err_cnt1);
    end
  endtask

  task automatic test_reset_mid_drain;
    logic saw_done;
    mode1 = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL drain_busy: got %0b want 1", busy1); end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    n_cmp++;
    if ({busy1, done1, op_a1, op_b1, err_cnt1, err_sum1, sse1, max1} !== '0) begin
      n_bad++; $display("FAIL reset_mid_drain: got busy=%0b done=%0b cnt=%0d sum=%0d sse=%0d max=%0d want all 0",
                        busy1, done1, err_cnt1, err_sum1, sse1, max1);
    end
    saw_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done1 || busy1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL reset_spurious_done: activity after reset, want none"); end
    $display("reset mid-drain: outputs checked");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    mode0 = 0; mode1 = 0;
    test_reset;
    test_exact_and_plus1;
    test_approx;
    test_abort;
    test_back_to_back;
    test_reset_mid_drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
